store_split_ctrl: RTL

STORE_SPLIT_CTRL -- requirements
Module: store_split_ctrl

---
 rtl/store_split_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/store_split_ctrl.sv
// Store split controller: turns sb/sh/sw requests into one or two word-aligned strobed memory beats.
// Optional macro STORE_SPLIT_EN enables two-beat word-crossing stores; otherwise crossing stores raise misalignErr.
module store_split_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  storeSrc,
  input  logic [31:0] storeAddress,
  input  logic [31:0] storeData,
  output logic        memValid,
  input  logic        memReady,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  writeStrobe,
  output logic        storeDone,
  output logic        misalignErr
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_done;
  logic        r_err;
  logic        w_accept;
  logic        w_last;
  logic [31:0] w_base;

  // Byte-lane mask before the word split; size 11 behaves as sw.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

`ifdef STORE_SPLIT_EN
  logic [7:0]  w_mask;
  logic [63:0] w_data;
  assign w_mask = lane_mask(r_size, r_addr[1:0]);
  assign w_data = {32'h0, r_data} << {r_addr[1:0], 3'b000};
`else
  logic [3:0]  w_mask;
  logic [31:0] w_data;
  logic [7:0]  w_in_mask;
  logic        w_cross;
  assign w_mask    = 4'(lane_mask(r_size, r_addr[1:0]));
  assign w_data    = r_data << {r_addr[1:0], 3'b000};
  assign w_in_mask = lane_mask(storeSrc, storeAddress[1:0]);
  assign w_cross   = |w_in_mask[7:4];
`endif

  assign w_accept    = reqValid & reqReady;
  assign w_base      = {r_addr[31:2], 2'b00};
  assign storeDone   = r_done;
  assign misalignErr = r_err;

  always_comb begin
    w_next       = r_state;
    w_last       = 1'b0;
    reqReady     = 1'b0;
    memValid     = 1'b0;
    memAddress   = 32'h0;
    memWriteData = 32'h0;
    writeStrobe  = 4'h0;
    case (r_state)
      IDLE: begin
        reqReady = 1'b1;
`ifdef STORE_SPLIT_EN
        if (w_accept) w_next = BEAT0;
`else
        if (w_accept && !w_cross) w_next = BEAT0;
`endif
      end
      BEAT0: begin
        memValid     = 1'b1;
        memAddress   = w_base;
        writeStrobe  = w_mask[3:0];
        memWriteData = w_data[31:0];
        if (memReady) begin
`ifdef STORE_SPLIT_EN
          if (|w_mask[7:4]) begin
            w_next = BEAT1;
          end else begin
            w_next = IDLE;
            w_last = 1'b1;
          end
`else
          w_next = IDLE;
          w_last = 1'b1;
`endif
        end
      end
`ifdef STORE_SPLIT_EN
      BEAT1: begin
        memValid     = 1'b1;
        memAddress   = w_base + 32'd4;
        writeStrobe  = w_mask[7:4];
        memWriteData = w_data[63:32];
        if (memReady) begin
          w_next = IDLE;
          w_last = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_size  <= 2'b00;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_size <= storeSrc;
        r_addr <= storeAddress;
        r_data <= storeData;
`ifndef STORE_SPLIT_EN
        // Crossing stores are consumed without a beat and flagged next cycle.
        r_err  <= w_cross;
`endif
      end
    end
  end

endmodule
